// File: rtl/pcie_lane_pkg.sv
// Shared constants for the PCIe byte-lane front end: lane width and source encodings.
package pcie_lane_pkg;

  localparam int   LANE_DATA_W = 8;
  localparam logic SRC_IN0     = 1'b0;
  localparam logic SRC_IN1     = 1'b1;

endpackage

// File: rtl/lane_fifo.sv
// Small per-source queue: power-of-2 depth, wrapping pointers, occupancy counter.
module lane_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage is not reset; the counter alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mux_rr_scheduler_2x1.sv
// Work-conserving round-robin scheduler: two queued sources share one registered 8-bit lane.
module mux_rr_scheduler_2x1
  import pcie_lane_pkg::*;
#(
  parameter int DATA_W     = LANE_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  q0_count,
  output logic [CNT_W-1:0]  q1_count
);

  // Handshake: a word moves across any valid/ready pair at the posedge where both are high;
  // the sender keeps data and valid stable until then, and ready never depends on valid.

  logic              full0, empty0, full1, empty1;
  logic              push0, push1, pop0, pop1;
  logic [DATA_W-1:0] pop_data0, pop_data1;
  logic              last_grant;
  logic              grant;
  logic              stage_free;
  logic              do_pop;

  assign in0_ready = reset_L & ~full0;
  assign in1_ready = reset_L & ~full1;
  assign push0     = in0_valid & in0_ready;
  assign push1     = in1_valid & in1_ready;

  lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_q0 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push0),
    .push_data (in0_data),
    .pop       (pop0),
    .pop_data  (pop_data0),
    .count     (q0_count),
    .full      (full0),
    .empty     (empty0)
  );

  lane_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_q1 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push1),
    .push_data (in1_data),
    .pop       (pop1),
    .pop_data  (pop_data1),
    .count     (q1_count),
    .full      (full1),
    .empty     (empty1)
  );

  // Only non-empty queues compete; on contention the port not served last wins.
  always_comb begin
    grant = last_grant;
    if (!empty0 && !empty1) grant = ~last_grant;
    else if (!empty0)       grant = SRC_IN0;
    else if (!empty1)       grant = SRC_IN1;
  end

  assign stage_free = ~out_valid | out_ready;
  assign do_pop     = stage_free & (~empty0 | ~empty1);
  assign pop0       = do_pop & (grant == SRC_IN0);
  assign pop1       = do_pop & (grant == SRC_IN1);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_src    <= SRC_IN0;
      last_grant <= SRC_IN1;
    end else if (do_pop) begin
      out_data   <= (grant == SRC_IN1) ? pop_data1 : pop_data0;
      out_src    <= grant;
      out_valid  <= 1'b1;
      last_grant <= grant;
    end else if (stage_free) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler_2x1.sv
// Directed bench for mux_rr_scheduler_2x1: reset, vector table, backpressure with scoreboard.
module tb_mux_rr_scheduler_2x1;

  logic       clk;
  logic       reset_L;
  logic [7:0] in0_data, in1_data, out_data;
  logic       in0_valid, in0_ready, in1_valid, in1_ready;
  logic       out_valid, out_src, out_ready;
  logic [2:0] q0_count, q1_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int pops    = 0;
  bit sb_on   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       v0; logic [7:0] d0;
    logic       v1; logic [7:0] d1;
    logic       ordy;
    logic       ov; logic [7:0] od; logic os;
    logic [2:0] c0; logic [2:0] c1;
    logic       r0; logic r1;
  } vec_t;

  vec_t vecs[$];

  mux_rr_scheduler_2x1 dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_src   (out_src),
    .out_ready (out_ready),
    .q0_count  (q0_count),
    .q1_count  (q1_count)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v0, input logic [7:0] d0, input logic v1,
                              input logic [7:0] d1, input logic ordy, input logic ov,
                              input logic [7:0] od, input logic os, input logic [2:0] c0,
                              input logic [2:0] c1, input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
    v.ov = ov; v.od = od; v.os = os; v.c0 = c0; v.c1 = c1; v.r0 = r0; v.r1 = r1;
    vecs.push_back(v);
  endfunction

  // occupancy bounds
  always @(negedge clk) begin
    if (reset_L) begin
      assert (q0_count <= 3'd4 && q1_count <= 3'd4)
      else begin
        err_cnt++;
        $error("count bound: q0=%0d q1=%0d", q0_count, q1_count);
      end
    end
  end

  // scoreboard: inputs are stable at negedge, so handshakes seen here complete at next posedge
  always @(negedge clk) begin
    if (sb_on && reset_L) begin
      if (in0_valid && in0_ready) exp_q.push_back(in0_data);
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) check("sb_underflow", {24'd0, out_data}, 32'hFFFF_FFFF);
        else check($sformatf("sb_word%0d", pops), {23'd0, out_src, out_data},
                   {23'd0, 1'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_idle();
    in0_valid = 1'b0; in0_data = 8'h00;
    in1_valid = 1'b0; in1_data = 8'h00;
  endtask

  initial begin
    logic [7:0] word;
    logic       acc;
    int         guard;

    reset_L = 1'b0; out_ready = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    #1;
    check("reset_state", {14'd0, out_valid, out_data, out_src, q0_count, q1_count, in0_ready, in1_ready},
          {14'd0, 1'b0, 8'h00, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1});

    // mid-operation reset discards queued and staged words
    for (int i = 0; i < 3; i++) begin
      in0_valid = 1'b1; in0_data = 8'h5A + 8'(i);
      @(posedge clk); #1;
    end
    drive_idle();
    check("pre_reset", {20'd0, out_valid, out_data, q0_count}, {20'd0, 1'b1, 8'h5A, 3'd2});
    reset_L = 1'b0;
    #1;
    check("in_reset_now", {19'd0, out_valid, out_data, q0_count, in0_ready},
          {19'd0, 1'b0, 8'h00, 3'd0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    check("in_reset_held", {27'd0, out_valid, q0_count, in0_ready}, {27'd0, 1'b0, 3'd0, 1'b0});
    reset_L = 1'b1;
    #1;
    check("ready_on_release", {31'd0, in0_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("no_stale%0d", i), {28'd0, out_valid, q0_count}, {28'd0, 1'b0, 3'd0});
    end

    // preload both queues under backpressure, then drain: strict alternation from port 0
    add(1, 8'hA0, 1, 8'hB0, 0,  0, 8'h00, 0, 1, 1, 1, 1);
    add(1, 8'hA1, 1, 8'hB1, 0,  1, 8'hA0, 0, 1, 2, 1, 1);
    add(1, 8'hA2, 1, 8'hB2, 0,  1, 8'hA0, 0, 2, 3, 1, 1);
    add(1, 8'hA3, 1, 8'hB3, 0,  1, 8'hA0, 0, 3, 4, 1, 0);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hB0, 1, 3, 3, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hA1, 0, 2, 3, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hB1, 1, 2, 2, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hA2, 0, 1, 2, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hB2, 1, 1, 1, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hA3, 0, 0, 1, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hB3, 1, 0, 0, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  0, 8'hB3, 1, 0, 0, 1, 1);
    // back-to-back stream on in0, one-edge latency
    add(1, 8'h11, 0, 8'h00, 1,  0, 8'hB3, 1, 1, 0, 1, 1);
    add(1, 8'h22, 0, 8'h00, 1,  1, 8'h11, 0, 1, 0, 1, 1);
    add(1, 8'h33, 0, 8'h00, 1,  1, 8'h22, 0, 1, 0, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'h33, 0, 0, 0, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  0, 8'h33, 0, 0, 0, 1, 1);
    // lone in1 grant, then contended grants alternate 0 then 1
    add(0, 8'h00, 1, 8'hD0, 1,  0, 8'h33, 0, 0, 1, 1, 1);
    add(1, 8'hE5, 1, 8'hD1, 1,  1, 8'hD0, 1, 1, 1, 1, 1);
    add(1, 8'hE6, 0, 8'h00, 1,  1, 8'hE5, 0, 1, 1, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hD1, 1, 1, 0, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hE6, 0, 0, 0, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  0, 8'hE6, 0, 0, 0, 1, 1);
    // same-edge push and pop on queue 1 at count 2
    add(0, 8'h00, 1, 8'hC0, 0,  0, 8'hE6, 0, 0, 1, 1, 1);
    add(0, 8'h00, 1, 8'hC1, 0,  1, 8'hC0, 1, 0, 1, 1, 1);
    add(0, 8'h00, 1, 8'hC2, 0,  1, 8'hC0, 1, 0, 2, 1, 1);
    add(0, 8'h00, 1, 8'hC3, 1,  1, 8'hC1, 1, 0, 2, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hC2, 1, 0, 1, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  1, 8'hC3, 1, 0, 0, 1, 1);
    add(0, 8'h00, 0, 8'h00, 1,  0, 8'hC3, 1, 0, 0, 1, 1);

    foreach (vecs[i]) begin
      in0_valid = vecs[i].v0; in0_data = vecs[i].d0;
      in1_valid = vecs[i].v1; in1_data = vecs[i].d1;
      out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            {14'd0, out_valid, out_data, out_src, q0_count, q1_count, in0_ready, in1_ready},
            {14'd0, vecs[i].ov, vecs[i].od, vecs[i].os, vecs[i].c0, vecs[i].c1,
             vecs[i].r0, vecs[i].r1});
    end
    drive_idle();

    // long backpressure while in0 streams: stage holds, queue fills, nothing lost after release
    sb_on = 1; out_ready = 1'b0; word = 8'h01;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in0_valid = 1'b1; in0_data = word;
      @(negedge clk); acc = in0_ready;
      @(posedge clk); #1;
      if (acc) word = word + 8'd1;
      if (cyc >= 1) check($sformatf("bp_hold%0d", cyc), {23'd0, out_valid, out_data},
                          {23'd0, 1'b1, 8'h01});
    end
    check("bp_full", {27'd0, q0_count, in0_ready, word[0]}, {27'd0, 3'd4, 1'b0, 1'b0});
    check("bp_next_word", {24'd0, word}, 32'h06);
    out_ready = 1'b1;
    guard = 0;
    while (word <= 8'h09 && guard < 40) begin
      in0_valid = 1'b1; in0_data = word;
      @(negedge clk); acc = in0_ready;
      @(posedge clk); #1;
      if (acc) word = word + 8'd1;
      guard++;
    end
    drive_idle();
    guard = 0;
    while ((exp_q.size() != 0 || q0_count != 0 || out_valid) && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    check("bp_drain_timeout", {31'd0, guard >= 30}, 32'd0);
    check("bp_pop_total", pops, 32'd9);
    sb_on = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
